// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small circular FIFO of {pc, inst}; flush beats push and pop
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output logic [2:0] count,
  output entry_t     head
);

  entry_t     mem_q [4];
  logic [1:0] rd_q;
  logic [1:0] wr_q;
  logic [2:0] cnt_q;

  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Storage array carries no reset; validity is tracked by the count alone
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy, cleared by reset or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= inc(wr_q);
      if (pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
    end
  end

  // Head reads as zero when empty so downstream never sees stale entries
  always_comb begin
    count = cnt_q;
    head  = (cnt_q == 3'd0) ? '0 : mem_q[rd_q];
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage; optional stall counter under FETCH_PERF_CNT_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [2:0]  count;
  entry_t      head;
  logic        can_issue;
  logic        push;
  logic        pop;

  assign can_issue = count < 3'(QUEUE_DEPTH);
  assign push      = (state_q == WAIT) && imem_ack && !redirect_valid;
  assign pop       = inst_valid && inst_ready && !redirect_valid;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({req_addr_q, imem_rdata}),
    .count (count),
    .head  (head)
  );

  // State, PC and outstanding request address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next state: a redirect mid-request must still wait out the memory ack in DROP
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (!redirect_valid && can_issue) ? WAIT : IDLE;
    else if (state_q == WAIT) state_d = imem_ack ? IDLE : (redirect_valid ? DROP : WAIT);
    else if (state_q == DROP) state_d = imem_ack ? IDLE : DROP;
    else state_d = IDLE;
  end

  // PC and request address next values; redirect always wins over sequential advance
  always_comb begin
    pc_d       = redirect_valid ? (redirect_pc & ~32'h3) : (push ? req_addr_q + PC_STEP : pc_q);
    req_addr_d = (state_q == IDLE && state_d == WAIT) ? pc_q : req_addr_q;
  end

  // Outputs decoded purely from registers
  always_comb begin
    imem_req   = (state_q == WAIT) || (state_q == DROP);
    imem_addr  = req_addr_q;
    inst_valid = count != 3'd0;
    inst       = head.inst;
    inst_pc    = head.pc;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;

  // Counts cycles where decode is ready but nothing is buffered, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else if (!inst_valid && inst_ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] exp_stall = '0;
`endif

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int lat_mode = -1;
  int pop_cnt = 0;

  logic [31:0] nf = RPC;
  logic [31:0] req_model = '0;
  bit          in_req = 0;
  bit          taint = 0;
  logic [63:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: acks after lat_mode cycles (random 0..3 when negative), forgets on reset
  bit busy = 0;
  int cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy = 0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack) busy = 0;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (!busy) begin
          busy = 1;
          cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end else if (cnt > 0) cnt--;
        imem_ack = (cnt == 0);
      end
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
  end

  // Monitor: reference is the sequential instruction stream restarted at each redirect
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      nf = RPC;
      in_req = 0;
      taint = 0;
      sb.delete();
`ifdef FETCH_PERF_CNT_EN
      exp_stall = '0;
`endif
    end else begin
      chk("valid_vs_model", {31'b0, inst_valid}, {31'b0, sb.size() != 0});
      if (!inst_valid) begin
        chk("empty_inst", inst, 32'h0);
        chk("empty_pc", inst_pc, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, exp_stall);
      if (sb.size() == 0 && inst_ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
      if (imem_req && !in_req) begin
        chk("req_addr", imem_addr, nf);
        in_req = 1;
        taint = 0;
        req_model = nf;
      end else if (imem_req) chk("req_stable", imem_addr, req_model);
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL pop_unexpected: got pc %h, expected empty queue", inst_pc);
        end else begin
          e = sb.pop_front();
          chk("inst_pc", inst_pc, e[63:32]);
          chk("inst", inst, e[31:0]);
          pop_cnt++;
        end
      end
      if (imem_ack && imem_req) begin
        if (!taint && !redirect_valid) begin
          sb.push_back({req_model, mem_word(req_model)});
          nf = req_model + 32'd4;
        end
        in_req = 0;
      end
      if (redirect_valid) begin
        sb.delete();
        nf = redirect_pc & ~32'h3;
        if (imem_req && in_req) taint = 1;
      end
      chk("occupancy", {31'b0, sb.size() > 2}, 32'h0);
    end
  end

  function automatic logic [31:0] pick_target();
    int k;
    k = int'($urandom_range(0, 3));
    return (k == 0) ? 32'h0000_0103 : (k == 1) ? 32'hFFFF_FFF8 :
           (k == 2) ? $urandom : (32'h0000_0400 | ($urandom & 32'hFF));
  endfunction

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    inst_ready = 1'b1;
    lat_mode = 1;
    repeat (30) step();

    lat_mode = 0;
    repeat (4) step();
    p0 = pop_cnt;
    repeat (40) step();
    chk("throughput", {31'b0, (pop_cnt - p0 >= 19) && (pop_cnt - p0 <= 21)}, 32'h1);

    lat_mode = 1;
    inst_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("full_req_idle", {31'b0, imem_req}, 32'h0);
    chk("full_valid", {31'b0, inst_valid}, 32'h1);
    chk("full_model_occ", 32'(sb.size()), 32'd2);
    step();
    inst_ready = 1'b1;
    repeat (12) step();

    lat_mode = 3;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    if (!imem_req) begin
      n_total++;
      $display("FAIL req_timeout: imem_req still 0 after 20 cycles");
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    repeat (25) step();

    lat_mode = 1;
    inst_ready = 1'b0;
    repeat (10) step();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_pop_valid", {31'b0, inst_valid}, 32'h0);
    repeat (20) step();

    lat_mode = -1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    repeat (25) step();

    for (int i = 0; i < 700; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 6);
      if (redirect_valid) redirect_pc = pick_target();
      step();
    end
    redirect_valid = 1'b0;

    inst_ready = 1'b1;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    #2 rst = 1'b1;
    repeat (2) step();
    #2 rst = 1'b0;
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
